// File: rtl/sdram_host_queue_if.sv
// Host request/response and SDRAM controller signal bundle for sdram_host_queue.
// The queue uses the slave view; the host side and controller model use the master view.
interface sdram_host_queue_if #(
    parameter int HADDR_WIDTH = 24
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [HADDR_WIDTH-1:0] req_addr;
    logic [15:0]            req_wdata;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [15:0]            resp_data;

    logic                   ctl_rd_enable;
    logic                   ctl_wr_enable;
    logic [HADDR_WIDTH-1:0] ctl_rd_addr;
    logic [HADDR_WIDTH-1:0] ctl_wr_addr;
    logic [15:0]            ctl_wr_data;
    logic                   ctl_busy;
    logic                   ctl_rd_ready;
    logic [15:0]            ctl_rd_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
               ctl_busy, ctl_rd_ready, ctl_rd_data,
        output req_ready, resp_valid, resp_data,
               ctl_rd_enable, ctl_wr_enable, ctl_rd_addr, ctl_wr_addr, ctl_wr_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
               ctl_busy, ctl_rd_ready, ctl_rd_data,
        input  req_ready, resp_valid, resp_data,
               ctl_rd_enable, ctl_wr_enable, ctl_rd_addr, ctl_wr_addr, ctl_wr_data
    );
endinterface

// File: rtl/sdram_host_queue.sv
// In-order request FIFO in front of an SDRAM controller with held enables and a one-entry read response.
// Define SDRAM_HOST_QUEUE_TIMEOUT_EN to add the sticky acknowledge-timeout error (err).
module sdram_host_queue #(
    parameter int HADDR_WIDTH = 24,
    parameter int DEPTH       = 4,
    parameter int PTR_W       = 2,
    parameter int ACK_TIMEOUT = 63
) (
    input  logic                clk,
    input  logic                rst_n,
    sdram_host_queue_if.slave   bus,
    output logic                err
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_WAIT_RD   = 2'd3;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    if (DEPTH < 2 || (1 << PTR_W) != DEPTH || ACK_TIMEOUT < 1) begin : g_bad_params
        $error("sdram_host_queue: invalid DEPTH/PTR_W/ACK_TIMEOUT");
    end

    logic                   fifo_we   [DEPTH];
    logic [HADDR_WIDTH-1:0] fifo_addr [DEPTH];
    logic [15:0]            fifo_data [DEPTH];

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic [1:0]             state_q, state_d;
    logic                   cur_we_q, cur_we_d;
    logic [HADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [15:0]            cur_data_q, cur_data_d;
    logic                   rd_seen_q, rd_seen_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [15:0]            resp_data_q, resp_data_d;
    logic                   push, pop, ack_timeout;
    logic                   fifo_empty, head_is_rd;

    assign bus.req_ready = (count_q != FULL_CNT);
    assign push          = bus.req_valid & bus.req_ready;
    assign fifo_empty    = (count_q == '0);
    assign head_is_rd    = ~fifo_we[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr_q]   <= bus.req_we;
            fifo_addr[wr_ptr_q] <= bus.req_addr;
            fifo_data[wr_ptr_q] <= bus.req_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_we_d   = cur_we_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        rd_seen_d  = rd_seen_q | bus.ctl_rd_ready;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A read may only start once the previous response slot is free.
                if (!fifo_empty && !bus.ctl_busy && !(head_is_rd && resp_valid_q)) begin
                    pop        = 1'b1;
                    cur_we_d   = fifo_we[rd_ptr_q];
                    cur_addr_d = fifo_addr[rd_ptr_q];
                    cur_data_d = fifo_data[rd_ptr_q];
                    rd_seen_d  = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.ctl_busy)     state_d = S_WAIT_DONE;
                else if (ack_timeout) state_d = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!bus.ctl_busy) begin
                    if (cur_we_q || rd_seen_q || bus.ctl_rd_ready) state_d = S_IDLE;
                    else                                          state_d = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (bus.ctl_rd_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        if (bus.ctl_rd_ready) begin
            resp_valid_d = 1'b1;
            resp_data_d  = bus.ctl_rd_data;
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            cur_we_q     <= 1'b0;
            cur_addr_q   <= '0;
            cur_data_q   <= '0;
            rd_seen_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cur_we_q     <= cur_we_d;
            cur_addr_q   <= cur_addr_d;
            cur_data_q   <= cur_data_d;
            rd_seen_q    <= rd_seen_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

`ifdef SDRAM_HOST_QUEUE_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    // Counts ISSUE cycles without acknowledge; the last one drops the request.
    assign ack_timeout = (state_q == S_ISSUE) && !bus.ctl_busy
                         && (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (pop)              to_cnt_d = '0;
        else if (ack_timeout) err_d    = 1'b1;
        else if (state_q == S_ISSUE && !bus.ctl_busy) to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign ack_timeout = 1'b0;
    assign err         = 1'b0;
`endif

    assign bus.ctl_wr_enable = (state_q == S_ISSUE) &  cur_we_q;
    assign bus.ctl_rd_enable = (state_q == S_ISSUE) & ~cur_we_q;
    assign bus.ctl_rd_addr   = cur_addr_q;
    assign bus.ctl_wr_addr   = cur_addr_q;
    assign bus.ctl_wr_data   = cur_data_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
endmodule

// File: doc/sdram_host_queue.md
Name: sdram_host_queue

Overview:
- Host-side request front-end that sits directly upstream of the SDRAM controller.
- Accepts read/write requests over a valid/ready handshake and buffers them in an in-order FIFO.
- Issues each request to the controller's single-shot enable interface, holding the enable until the controller's registered busy acknowledges it. This absorbs refresh preemption and busy lag.
- Returns read data on a one-entry valid/ready response port.

Parameters:
- HADDR_WIDTH, 24, host address width (bank+row+col).
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).
- ACK_TIMEOUT, 63, cycles to wait for busy=1 after enable before flagging an error (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  FIFO not full.
- req_we  in  1  1=write, 0=read.
- req_addr  in  HADDR_WIDTH  request address.
- req_wdata  in  16  write data.
- resp_valid  out  1  read data held.
- resp_ready  in  1  host consumes response.
- resp_data  out  16  read data.
- ctl_rd_enable  out  1  to controller rd_enable.
- ctl_wr_enable  out  1  to controller wr_enable.
- ctl_rd_addr  out  HADDR_WIDTH  to controller rd_addr.
- ctl_wr_addr  out  HADDR_WIDTH  to controller wr_addr.
- ctl_wr_data  out  16  to controller wr_data.
- ctl_busy  in  1  controller busy (registered, lags state by 1 cycle).
- ctl_rd_ready  in  1  controller read-data strobe.
- ctl_rd_data  in  16  controller read data.
- err  out  1  sticky acknowledge timeout (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: asynchronous, active-low. Clears FIFO pointers and count, FSM to IDLE, resp_valid=0, resp_data=0, ctl_*_enable=0, err=0. req_ready=1 after reset.
- Reset mid-operation: an in-flight request is abandoned; no replay.
- FIFO:
  - Push on req_valid&req_ready; req_ready = (count!=DEPTH).
  - Pop when the FSM leaves IDLE into ISSUE.
  - Simultaneous push and pop when full is not allowed: req_ready is low at full.
  - Push and pop in the same cycle at a non-full count leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Controller outputs: ctl_rd_addr, ctl_wr_addr and ctl_wr_data are driven from a registered "current request" (cur_we, cur_addr, cur_data) loaded at pop. Both address ports carry cur_addr.
- FSM states:
  - IDLE: if FIFO non-empty and ctl_busy=0 and !(head is a read && resp_valid), pop into cur and go to ISSUE.
  - ISSUE: assert ctl_wr_enable if cur_we, else ctl_rd_enable. Hold it every cycle until ctl_busy=1 is sampled, then deassert and go to WAIT_DONE. The enable is held through refresh: if the controller enters refresh instead of accepting, busy stays 0 and the enable stays high. Re-latching the same address and data while the controller is active is harmless.
  - WAIT_DONE: wait for ctl_busy=0.
    - Write: go to IDLE.
    - Read: if ctl_rd_ready already captured, go to IDLE. Otherwise go to WAIT_RD.
  - WAIT_RD: on ctl_rd_ready go to IDLE.
- Read capture: in any state, ctl_rd_ready=1 loads resp_data<=ctl_rd_data and sets resp_valid=1 the next cycle. resp_valid clears on resp_valid&resp_ready. A read is never issued while resp_valid=1, so capture never overwrites an unconsumed response.
- Ordering: strictly in order, one outstanding request.
- Minimum latency: push to ctl enable assertion = 2 cycles with FIFO empty and controller idle (1 to write FIFO, 1 to pop into cur).

Optional Feature:
- Macro: SDRAM_HOST_QUEUE_TIMEOUT_EN.
- When defined, a counter runs in ISSUE, cleared on entry.
- If it reaches ACK_TIMEOUT with ctl_busy still 0:
  - err is set, sticky until reset;
  - the enable is dropped, the request is discarded, and the FSM returns to IDLE.
- When undefined: no counter, err tied to 0, ISSUE waits indefinitely.

Test Plan:
- Write then read: push write addr 0x000123 data 0xBEEF, then read 0x000123 -> exactly one ctl_wr_enable burst, then one ctl_rd_enable. resp_valid with resp_data=0xBEEF after the stub returns it.
- Refresh preemption: stub keeps busy=0 for 10 cycles after enable, then raises it -> enable held high all 10 cycles, deasserted the cycle after busy=1, one transaction recorded.
- FIFO full: hold ctl_busy=1 and push 5 requests -> req_ready=0 after the 4th. 5th accepted only after the first pop. Order preserved (addresses 1,2,3,4,5).
- Response backpressure: two reads with resp_ready=0 -> second read not issued until resp_ready pulses. Both data values returned in order.
- Async reset mid-read: drop rst_n during WAIT_RD -> outputs zero immediately without a clock edge, req_ready=1 after release.
- With SDRAM_HOST_QUEUE_TIMEOUT_EN, ACK_TIMEOUT=8, stub never raises busy -> err=1 after 8 ISSUE cycles, enable low, next request still serviced.
